// File: rtl/layer_result_pingpong_mem.sv
// Double-buffered feature-map store: one bank is filled by the layer writer while the other is drained by the reader.
// Reads return data one cycle after request; writes are gated by save_ready and reads are gated by read_ready.
module layer_result_pingpong_mem #(
  parameter int DATA_W = 128,
  parameter int ROWS   = 14,
  parameter int COLS   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              save_enable,
  input  logic [15:0]       save_row_addr,
  input  logic [15:0]       save_col_addr,
  input  logic [DATA_W-1:0] save_data_in,
  input  logic              save_frame_done,
  output logic              save_ready,
  input  logic              read_signal,
  input  logic [15:0]       read_row_addr,
  input  logic [15:0]       read_col_addr,
  input  logic              read_release,
  output logic              read_ready,
  output logic              read_valid,
  output logic [DATA_W-1:0] result_output,
  output logic              wr_sel,
  output logic              rd_sel,
  output logic [2:0]        err
);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_WRITING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

  logic [1:0]        state_q [2];
  logic [1:0]        state_d [2];
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic              read_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        err_q, err_d;
  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_in_range, rd_in_range;
  logic          wr_fire, rd_fire;

  assign wr_addr = AW'(32'(save_row_addr) * 32'(COLS) + 32'(save_col_addr));
  assign rd_addr = AW'(32'(read_row_addr) * 32'(COLS) + 32'(read_col_addr));
  assign wr_in_range = (32'(save_row_addr) < 32'(ROWS)) && (32'(save_col_addr) < 32'(COLS));
  assign rd_in_range = (32'(read_row_addr) < 32'(ROWS)) && (32'(read_col_addr) < 32'(COLS));

  assign save_ready = (state_q[wr_sel_q] == ST_EMPTY) || (state_q[wr_sel_q] == ST_WRITING);
  assign read_ready = (state_q[rd_sel_q] == ST_FULL)  || (state_q[rd_sel_q] == ST_READING);
  assign wr_fire    = save_enable && save_ready && wr_in_range;
  assign rd_fire    = read_signal && read_ready && rd_in_range;

  // When wr_sel == rd_sel only one side can be ready, so the two sides never touch the same bank.
  always_comb begin
    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    err_d    = err_q;
    if (save_enable) begin
      if (!save_ready)  err_d[0] = 1'b1;
      if (!wr_in_range) err_d[2] = 1'b1;
    end
    if (read_signal) begin
      if (!read_ready)  err_d[1] = 1'b1;
      if (!rd_in_range) err_d[2] = 1'b1;
    end
    if (save_ready) begin
      if (save_frame_done) begin
        state_d[wr_sel_q] = ST_FULL;
        wr_sel_d          = ~wr_sel_q;
      end else if (wr_fire && state_q[wr_sel_q] == ST_EMPTY) begin
        state_d[wr_sel_q] = ST_WRITING;
      end
    end
    if (read_ready) begin
      if (read_release) begin
        state_d[rd_sel_q] = ST_EMPTY;
        rd_sel_d          = ~rd_sel_q;
      end else if (rd_fire && state_q[rd_sel_q] == ST_FULL) begin
        state_d[rd_sel_q] = ST_READING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0]   <= ST_EMPTY;
      state_q[1]   <= ST_EMPTY;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      read_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= '0;
    end else if (flush) begin
      state_q[0]   <= ST_EMPTY;
      state_q[1]   <= ST_EMPTY;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      read_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      read_valid_q <= rd_fire;
      rdata_q      <= rd_fire ? mem_q[rd_sel_q][rd_addr] : '0;
      err_q        <= err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire && !flush && !rst) mem_q[wr_sel_q][wr_addr] <= save_data_in;
  end

  assign read_valid    = read_valid_q;
  assign result_output = rdata_q;
  assign wr_sel        = wr_sel_q;
  assign rd_sel        = rd_sel_q;
  assign err           = err_q;
endmodule

// File: tb/tb_layer_result_pingpong_mem.sv
// Directed bench for layer_result_pingpong_mem; read data is checked by a scoreboard monitor on the falling edge.
module tb_layer_result_pingpong_mem;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst, flush, save_enable, save_frame_done, read_signal, read_release;
  logic [15:0]   save_row_addr, save_col_addr, read_row_addr, read_col_addr;
  logic [DW-1:0] save_data_in;
  logic          save_ready, read_ready, read_valid, wr_sel, rd_sel;
  logic [DW-1:0] result_output;
  logic [2:0]    err;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [$];

  layer_result_pingpong_mem #(.DATA_W(DW), .ROWS(14), .COLS(14)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .save_enable(save_enable), .save_row_addr(save_row_addr), .save_col_addr(save_col_addr),
    .save_data_in(save_data_in), .save_frame_done(save_frame_done), .save_ready(save_ready),
    .read_signal(read_signal), .read_row_addr(read_row_addr), .read_col_addr(read_col_addr),
    .read_release(read_release), .read_ready(read_ready), .read_valid(read_valid),
    .result_output(result_output), .wr_sel(wr_sel), .rd_sel(rd_sel), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (read_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_valid: got data %0d with no read outstanding", result_output);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_data", result_output, e);
      end
    end else begin
      chk("sb_idle_zero", result_output, 128'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; save_enable = 0; save_frame_done = 0; read_signal = 0; read_release = 0;
  endtask

  task automatic wr(input int r, input int c, input int d, input logic fd);
    save_enable = 1; save_row_addr = 16'(r); save_col_addr = 16'(c);
    save_data_in = DW'(d); save_frame_done = fd;
    tick();
    save_enable = 0; save_frame_done = 0;
  endtask

  task automatic frame_done();
    save_frame_done = 1;
    tick();
    save_frame_done = 0;
  endtask

  task automatic rd(input int r, input int c, input int exp, input logic push, input logic rel);
    read_signal = 1; read_row_addr = 16'(r); read_col_addr = 16'(c); read_release = rel;
    if (push) exp_q.push_back(DW'(exp));
    tick();
    read_signal = 0; read_release = 0;
  endtask

  initial begin
    idle();
    save_row_addr = 0; save_col_addr = 0; save_data_in = 0;
    read_row_addr = 0; read_col_addr = 0;
    rst = 1;
    repeat (3) tick();
    chk("rst_save_ready", 128'(save_ready), 128'(1));
    chk("rst_read_ready", 128'(read_ready), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_sels", 128'({wr_sel, rd_sel}), 128'(0));
    rst = 0;
    tick();

    // Full frame into bank0, data = row*14+col.
    for (int i = 0; i < 196; i++) wr(i / 14, i % 14, i, 1'b0);
    frame_done();
    chk("f0_wr_sel", 128'(wr_sel), 128'(1));
    chk("f0_read_ready", 128'(read_ready), 128'(1));
    chk("f0_save_ready", 128'(save_ready), 128'(1));
    rd(3, 5, 47, 1'b1, 1'b0);
    chk("f0_valid_after_1", 128'(read_valid), 128'(1));
    rd(13, 13, 195, 1'b1, 1'b0);
    rd(0, 0, 0, 1'b1, 1'b0);
    chk("f0_err_clean", 128'(err), 128'(0));

    // Bank1 filled; last word + frame_done coincides with read + release of bank0.
    for (int i = 0; i < 195; i++) wr(i / 14, i % 14, 1000 + i, 1'b0);
    save_enable = 1; save_row_addr = 13; save_col_addr = 13; save_data_in = DW'(1195); save_frame_done = 1;
    read_signal = 1; read_row_addr = 2; read_col_addr = 2; read_release = 1;
    exp_q.push_back(DW'(30));
    tick();
    idle();
    chk("swap_rd_sel", 128'(rd_sel), 128'(1));
    chk("swap_wr_sel", 128'(wr_sel), 128'(0));
    chk("swap_bank0_empty", 128'(save_ready), 128'(1));
    chk("swap_read_ready", 128'(read_ready), 128'(1));
    rd(13, 13, 1195, 1'b1, 1'b0);
    rd(7, 3, 1101, 1'b1, 1'b0);

    // Both banks full: writes are refused and frame_done ignored.
    wr(0, 0, 5555, 1'b0);
    frame_done();
    chk("full_save_ready", 128'(save_ready), 128'(0));
    wr(0, 0, 9999, 1'b0);
    chk("overflow_err", 128'(err), 128'(3'b001));
    frame_done();
    chk("ignored_fd_wr_sel", 128'(wr_sel), 128'(1));
    rd(0, 0, 1000, 1'b1, 1'b1);
    chk("release_rd_sel", 128'(rd_sel), 128'(0));
    chk("release_save_ready", 128'(save_ready), 128'(1));
    rd(0, 0, 5555, 1'b1, 1'b0);

    // Flush overrides a simultaneous valid read.
    flush = 1; read_signal = 1; read_row_addr = 1; read_col_addr = 1;
    tick();
    idle();
    chk("flush_err", 128'(err), 128'(0));
    chk("flush_sels", 128'({wr_sel, rd_sel}), 128'(0));
    chk("flush_save_ready", 128'(save_ready), 128'(1));
    chk("flush_read_ready", 128'(read_ready), 128'(0));
    chk("flush_no_valid", 128'(read_valid), 128'(0));

    // Read right after reset underflows.
    rst = 1; tick(); rst = 0; tick();
    rd(5, 5, 0, 1'b0, 1'b0);
    chk("underflow_err", 128'(err), 128'(3'b010));
    chk("underflow_no_valid", 128'(read_valid), 128'(0));
    chk("underflow_zero", result_output, 128'(0));

    // Out-of-range coordinates: (0,14) would alias (1,0) if not suppressed.
    rst = 1; tick(); rst = 0; tick();
    wr(1, 0, 11, 1'b0);
    wr(0, 14, 99, 1'b0);
    chk("oor_wr_err", 128'(err), 128'(3'b100));
    wr(14, 0, 88, 1'b0);
    frame_done();
    chk("oor_read_ready", 128'(read_ready), 128'(1));
    rd(0, 14, 0, 1'b0, 1'b0);
    chk("oor_rd_no_valid", 128'(read_valid), 128'(0));
    chk("oor_rd_err", 128'(err), 128'(3'b100));
    rd(1, 0, 11, 1'b1, 1'b0);

    // Reset one cycle after a read request kills the pending beat at once.
    tick();
    rd(1, 0, 11, 1'b0, 1'b0);
    rst = 1;
    #1;
    chk("rst_mid_valid", 128'(read_valid), 128'(0));
    chk("rst_mid_data", result_output, 128'(0));
    tick();
    rst = 0;
    tick();
    chk("post_rst_save_ready", 128'(save_ready), 128'(1));
    chk("post_rst_read_ready", 128'(read_ready), 128'(0));
    chk("post_rst_err", 128'(err), 128'(0));

    repeat (3) tick();
    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_result_pingpong_mem.md
LAYER_RESULT_PINGPONG_MEM -- requirements
Module: layer_result_pingpong_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the width in bits of one feature-map word.
REQ-002 SHALL have parameter ROWS, default 14, meaning the feature-map height.
REQ-003 SHALL have parameter COLS, default 14, meaning the feature-map width.
REQ-004 SHALL derive local parameter DEPTH = ROWS*COLS and AW = clog2(DEPTH) (8 at defaults).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1 bit: synchronous return of both banks to EMPTY.
REQ-008 SHALL have port save_enable, input, 1 bit: a write request.
REQ-009 SHALL have ports save_row_addr and save_col_addr, input, 16 bits each: the write coordinates.
REQ-010 SHALL have port save_data_in, input, DATA_W: the write data.
REQ-011 SHALL have port save_frame_done, input, 1 bit: a pulse closing the current write frame.
REQ-012 SHALL have port save_ready, output, 1 bit: the write bank accepts data.
REQ-013 SHALL have port read_signal, input, 1 bit: a read request.
REQ-014 SHALL have ports read_row_addr and read_col_addr, input, 16 bits each: the read coordinates.
REQ-015 SHALL have port read_release, input, 1 bit: a pulse freeing the current read bank.
REQ-016 SHALL have port read_ready, output, 1 bit: the read bank holds a complete frame.
REQ-017 SHALL have port read_valid, output, 1 bit: result_output is valid this cycle.
REQ-018 SHALL have port result_output, output, DATA_W: the read data.
REQ-019 SHALL have ports wr_sel and rd_sel, output, 1 bit each: the currently selected bank indices.
REQ-020 SHALL have port err, output, 3 bits, sticky: {addr_range, underflow, overflow}.

Function
REQ-021 SHALL hold two banks of DEPTH x DATA_W, each with a state EMPTY, WRITING, FULL or READING.
REQ-022 SHALL compute the linear address row*COLS+col, truncated to AW bits, for both write and read.
REQ-023 SHALL treat row>=ROWS or col>=COLS as out of range: the write or read is suppressed and err[2] is set.
REQ-024 SHALL drive save_ready=1 iff bank[wr_sel] is EMPTY or WRITING.
REQ-025 SHALL drive read_ready=1 iff bank[rd_sel] is FULL or READING.
REQ-026 SHALL, on save_enable with save_ready, write bank[wr_sel] at the edge and move an EMPTY bank to WRITING.
REQ-027 SHALL drop save_enable when save_ready=0, leave memory unchanged, and set err[0].
REQ-028 SHALL, on save_frame_done with save_ready, move bank[wr_sel] to FULL and toggle wr_sel; a write in the same cycle is stored first.
REQ-029 SHALL ignore save_frame_done when save_ready=0.
REQ-030 SHALL, on read_signal with read_ready, register the read and assert read_valid with the data exactly 1 cycle later; FULL moves to READING.
REQ-031 SHALL, on read_signal without read_ready, suppress the read and set err[1]; read_valid stays 0.
REQ-032 SHALL drive result_output to 0 whenever read_valid=0.
REQ-033 SHALL, on read_release with read_ready, move bank[rd_sel] to EMPTY and toggle rd_sel; a read in the same cycle still returns its data next cycle.
REQ-034 SHALL ignore read_release when read_ready=0.
REQ-035 SHALL process write-side and read-side events independently in the same cycle (wr_sel and rd_sel can never target a WRITING and a READING bank simultaneously).
REQ-036 SHALL, on flush, set both banks EMPTY, wr_sel=rd_sel=0, read_valid=0 and err=0, leave memory contents undefined, and override all other inputs that cycle.
REQ-037 SHALL not reset the memory array.

Reset
REQ-038 SHALL, while rst=1 (asynchronous), force both banks EMPTY, wr_sel=0, rd_sel=0, read_valid=0, result_output=0 and err=0, so that save_ready=1 and read_ready=0.
REQ-039 SHALL abandon an in-progress frame when rst is asserted mid-frame, with no pending read_valid after release.

Verification
REQ-040 SHALL pass this scenario: write 196 words with data=row*14+col, then pulse frame_done -> wr_sel=1, read_ready=1; read (3,5) -> one cycle later read_valid=1 and result_output=47.
REQ-041 SHALL pass this scenario: fill bank0 and bank1 with no release -> save_ready=0; a further save_enable sets err[0] and both banks are unchanged.
REQ-042 SHALL pass this scenario: issue read_signal after reset -> err[1]=1, read_valid=0, result_output=0.
REQ-043 SHALL pass this scenario: write to (14,0), then read (0,14) -> err[2]=1, no memory change, no read_valid.
REQ-044 SHALL pass this scenario: in one cycle, write the last word of bank1 with frame_done while reading bank0 with release -> next cycle: read data valid, rd_sel=1, wr_sel=0, bank0 EMPTY.
REQ-045 SHALL pass this scenario: assert rst mid-read, one cycle after read_signal -> read_valid=0 immediately; after rst deasserts, save_ready=1 and read_ready=0.
